// File: rtl/bridge_datapath_pkg.sv
// Shared definitions for the bridge datapath: the command word layout {mode, data, addr}
// and helpers that derive its width and field positions from the block parameters.
package bridge_datapath_pkg;

   typedef enum logic {
      CMD_READ  = 1'b0,
      CMD_WRITE = 1'b1
   } cmd_mode_e;

   localparam int CMD_ADDR_LSB = 0;

   function automatic int cmd_width(input int data_w, input int addr_w);
      return 1 + data_w + addr_w;
   endfunction

   function automatic int cmd_data_lsb(input int addr_w);
      return addr_w;
   endfunction

   function automatic int cmd_mode_bit(input int data_w, input int addr_w);
      return addr_w + data_w;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// First-word-fall-through command queue; the head entry is visible on dout while not empty.
// A push into a full queue is accepted only when a pop happens in the same cycle.
module cmd_fifo #(
   parameter int WIDTH = 21,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             enq,
   input  logic             deq,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign do_pop  = deq && !empty;
   assign do_push = enq && (!full || do_pop);

   // Storage is not cleared on reset, so the head is masked until something is queued.
   assign dout = empty ? '0 : mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: queue storage has no reset; only the pointers and count define its contents.
   always_ff @(posedge clk) begin
      if (rstn && do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/bridge_datapath.sv
// Bridge datapath: command queue, compact-to-bus address converter and a local byte RAM.
// Define BRIDGE_DATAPATH_TRACE_EN to print each accepted queue push and each RAM write.
module bridge_datapath
   import bridge_datapath_pkg::*;
#(
   parameter int ADDR_WIDTH           = 16,
   parameter int DATA_WIDTH           = 8,
   parameter int BB_ADDR_WIDTH        = 12,
   parameter int SLAVE_MEM_ADDR_WIDTH = 12,
   parameter int FIFO_DEPTH           = 8,
   parameter int LOCAL_MEM_SIZE       = 2048,
   parameter int LOCAL_MEM_ADDR_WIDTH = 11,
   localparam int CW = cmd_width(DATA_WIDTH, BB_ADDR_WIDTH)
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic                            cmd_enq,
   input  logic                            cmd_deq,
   input  logic [CW-1:0]                   cmd_din,
   output logic [CW-1:0]                   cmd_dout,
   output logic                            cmd_empty,
   output logic                            cmd_full,
   input  logic [BB_ADDR_WIDTH-1:0]        bb_addr,
   output logic [ADDR_WIDTH-1:0]           bus_addr,
   input  logic                            lmem_wen,
   input  logic                            lmem_ren,
   input  logic [LOCAL_MEM_ADDR_WIDTH-1:0] lmem_addr,
   input  logic [DATA_WIDTH-1:0]           lmem_wdata,
   output logic [DATA_WIDTH-1:0]           lmem_rdata,
   output logic                            lmem_rvalid
);

   cmd_fifo #(
      .WIDTH (CW),
      .DEPTH (FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .enq   (cmd_enq),
      .deq   (cmd_deq),
      .din   (cmd_din),
      .dout  (cmd_dout),
      .empty (cmd_empty),
      .full  (cmd_full)
   );

   // Top two compact-address bits select the slave; the rest is that slave's offset.
   logic [1:0]                      slave_id;
   logic [SLAVE_MEM_ADDR_WIDTH-1:0] slave_off;

   assign slave_id  = bb_addr[BB_ADDR_WIDTH-1 -: 2];
   assign slave_off = SLAVE_MEM_ADDR_WIDTH'(bb_addr[BB_ADDR_WIDTH-3:0]);

   // NOTE: the whole output is defaulted before the field writes so no latch is inferred.
   always_comb begin
      bus_addr = '0;
      bus_addr[SLAVE_MEM_ADDR_WIDTH-1:0]    = slave_off;
      bus_addr[SLAVE_MEM_ADDR_WIDTH+1 -: 2] = slave_id;
   end

   logic [DATA_WIDTH-1:0]           ram [LOCAL_MEM_SIZE];
   logic [LOCAL_MEM_ADDR_WIDTH-1:0] ram_idx;

   assign ram_idx = LOCAL_MEM_ADDR_WIDTH'(32'(lmem_addr) % 32'(LOCAL_MEM_SIZE));

   // The read samples the array before this edge's write lands, giving read-before-write.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         lmem_rdata  <= '0;
         lmem_rvalid <= 1'b0;
      end else begin
         lmem_rvalid <= lmem_ren;
         if (lmem_ren) lmem_rdata <= ram[ram_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (rstn && lmem_wen) ram[ram_idx] <= lmem_wdata;
   end

`ifdef BRIDGE_DATAPATH_TRACE_EN
   always_ff @(posedge clk) begin
      if (rstn && cmd_enq && (!cmd_full || (cmd_deq && !cmd_empty)))
         $display("%0t cmd push mode=%s data=0x%0h addr=0x%0h", $time,
                  cmd_mode_e'(cmd_din[cmd_mode_bit(DATA_WIDTH, BB_ADDR_WIDTH)]).name(),
                  cmd_din[cmd_data_lsb(BB_ADDR_WIDTH) +: DATA_WIDTH],
                  cmd_din[CMD_ADDR_LSB +: BB_ADDR_WIDTH]);
      if (rstn && lmem_wen)
         $display("%0t ram write addr=0x%0h data=0x%0h", $time, ram_idx, lmem_wdata);
   end
`else
`endif

endmodule

// File: tb/tb_bridge_datapath.sv
// Self-checking bench for bridge_datapath: a queue/array reference model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_bridge_datapath;

   localparam int CW = 21;

   logic        clk = 1'b0;
   logic        rstn;
   logic        cmd_enq, cmd_deq;
   logic [20:0] cmd_din, cmd_dout;
   logic        cmd_empty, cmd_full;
   logic [11:0] bb_addr;
   logic [15:0] bus_addr;
   logic        lmem_wen, lmem_ren;
   logic [10:0] lmem_addr;
   logic [7:0]  lmem_wdata, lmem_rdata;
   logic        lmem_rvalid;

   int n_checks = 0;
   int n_fail   = 0;
   bit mon_en   = 1'b0;

   always #5 clk = ~clk;

   bridge_datapath dut (
      .clk         (clk),
      .rstn        (rstn),
      .cmd_enq     (cmd_enq),
      .cmd_deq     (cmd_deq),
      .cmd_din     (cmd_din),
      .cmd_dout    (cmd_dout),
      .cmd_empty   (cmd_empty),
      .cmd_full    (cmd_full),
      .bb_addr     (bb_addr),
      .bus_addr    (bus_addr),
      .lmem_wen    (lmem_wen),
      .lmem_ren    (lmem_ren),
      .lmem_addr   (lmem_addr),
      .lmem_wdata  (lmem_wdata),
      .lmem_rdata  (lmem_rdata),
      .lmem_rvalid (lmem_rvalid)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Reference model: queue of up to 8 words, byte array, registered read result.
   logic [20:0] m_q[$];
   logic [7:0]  m_ram [2048];
   logic [7:0]  m_rdata  = 8'h00;
   logic        m_rvalid = 1'b0;

   function automatic logic [15:0] model_bus(input logic [11:0] a);
      int id  = (int'(a) >> 10) & 3;
      int off = int'(a) & 'h3FF;
      return 16'((id << 12) + off);
   endfunction

   always @(posedge clk) begin
      if (!rstn) begin
         m_q.delete();
         m_rdata  = 8'h00;
         m_rvalid = 1'b0;
      end else begin
         bit pop, push;
         pop  = cmd_deq && (m_q.size() > 0);
         push = cmd_enq && ((m_q.size() < 8) || pop);
         if (lmem_ren) m_rdata = m_ram[int'(lmem_addr) % 2048];
         m_rvalid = lmem_ren;
         if (lmem_wen) m_ram[int'(lmem_addr) % 2048] = lmem_wdata;
         if (pop)  void'(m_q.pop_front());
         if (push) m_q.push_back(cmd_din);
      end
   end

   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         check("mon_empty",  32'(cmd_empty),   32'(m_q.size() == 0));
         check("mon_full",   32'(cmd_full),    32'(m_q.size() == 8));
         check("mon_dout",   32'(cmd_dout),    (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
         check("mon_rvalid", 32'(lmem_rvalid), 32'(m_rvalid));
         check("mon_rdata",  32'(lmem_rdata),  32'(m_rdata));
         check("mon_bus",    32'(bus_addr),    32'(model_bus(bb_addr)));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [20:0] e [9];
      logic [20:0] extra;

      rstn = 1'b0; cmd_enq = 1'b0; cmd_deq = 1'b0; cmd_din = '0; bb_addr = '0;
      lmem_wen = 1'b0; lmem_ren = 1'b0; lmem_addr = '0; lmem_wdata = '0;
      tick(); tick();
      rstn = 1'b1;
      mon_en = 1'b1;
      check("rst_empty",  32'(cmd_empty),   32'h1);
      check("rst_full",   32'(cmd_full),    32'h0);
      check("rst_rvalid", 32'(lmem_rvalid), 32'h0);
      check("rst_rdata",  32'(lmem_rdata),  32'h0);
      check("rst_dout",   32'(cmd_dout),    32'h0);

      // Three pushes then three pops, head visible before each pop.
      cmd_enq = 1'b1;
      cmd_din = 21'h1AB123; tick();
      cmd_din = 21'h000456; tick();
      cmd_din = 21'h1CD789; tick();
      cmd_enq = 1'b0;
      check("fwft_head0", 32'(cmd_dout), 32'h1AB123);
      cmd_deq = 1'b1; tick();
      check("fwft_head1", 32'(cmd_dout), 32'h000456);
      tick();
      check("fwft_head2", 32'(cmd_dout), 32'h1CD789);
      tick();
      cmd_deq = 1'b0;
      check("fwft_empty", 32'(cmd_empty), 32'h1);

      // Fill to full, drop the 9th, then push+pop while full.
      for (int i = 0; i < 9; i++) e[i] = {1'b0, 8'(i + 8'h10), 12'(i + 12'h200)};
      cmd_enq = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cmd_din = e[i];
         tick();
         check("fill_full", 32'(cmd_full), (i == 7) ? 32'h1 : 32'h0);
      end
      cmd_din = e[8]; tick();
      check("drop_full", 32'(cmd_full), 32'h1);
      check("drop_head", 32'(cmd_dout), 32'(e[0]));
      extra = 21'h1EE0AA;
      cmd_din = extra; cmd_deq = 1'b1; tick();
      cmd_enq = 1'b0;
      check("swap_full", 32'(cmd_full), 32'h1);
      check("swap_head", 32'(cmd_dout), 32'(e[1]));
      for (int i = 1; i < 8; i++) begin
         check("drain_order", 32'(cmd_dout), 32'(e[i]));
         tick();
      end
      check("drain_last", 32'(cmd_dout), 32'(extra));
      tick();
      cmd_deq = 1'b0;
      check("drain_empty", 32'(cmd_empty), 32'h1);

      // Address converter.
      bb_addr = 12'h000; #1; check("bus_000", 32'(bus_addr), 32'h0000);
      bb_addr = 12'h5A3; #1; check("bus_5A3", 32'(bus_addr), 32'h11A3);
      bb_addr = 12'hFFF; #1; check("bus_FFF", 32'(bus_addr), 32'h33FF);
      bb_addr = 12'h800; #1; check("bus_800", 32'(bus_addr), 32'h2000);

      // RAM write then read at the top address.
      lmem_wen = 1'b1; lmem_addr = 11'h7FF; lmem_wdata = 8'h5A; tick();
      lmem_wen = 1'b0; lmem_ren = 1'b1; tick();
      lmem_ren = 1'b0;
      check("ram_rvalid1", 32'(lmem_rvalid), 32'h1);
      check("ram_rdata",   32'(lmem_rdata),  32'h5A);
      tick();
      check("ram_rvalid0", 32'(lmem_rvalid), 32'h0);
      check("ram_hold",    32'(lmem_rdata),  32'h5A);

      // Read-before-write on the same address.
      lmem_wen = 1'b1; lmem_addr = 11'h100; lmem_wdata = 8'h11; tick();
      lmem_ren = 1'b1; lmem_wdata = 8'h22; tick();
      lmem_wen = 1'b0; lmem_ren = 1'b0;
      check("rbw_old", 32'(lmem_rdata), 32'h11);
      lmem_ren = 1'b1; tick();
      lmem_ren = 1'b0;
      check("rbw_new", 32'(lmem_rdata), 32'h22);

      // Reset mid-stream with entries queued and a read and push requested.
      cmd_enq = 1'b1;
      cmd_din = 21'h0AA001; tick();
      cmd_din = 21'h0BB002; tick();
      cmd_din = 21'h0CC003; tick();
      rstn = 1'b0; lmem_ren = 1'b1; lmem_addr = 11'h7FF; cmd_din = 21'h0DD004; tick();
      check("mid_empty",  32'(cmd_empty),   32'h1);
      check("mid_rvalid", 32'(lmem_rvalid), 32'h0);
      check("mid_rdata",  32'(lmem_rdata),  32'h0);
      check("mid_dout",   32'(cmd_dout),    32'h0);
      rstn = 1'b1; lmem_ren = 1'b0; cmd_din = 21'h1EF0F0; tick();
      cmd_enq = 1'b0;
      check("post_head", 32'(cmd_dout), 32'h1EF0F0);
      tick(); tick();

      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
